// File: rtl/led_pkg.sv
// Shared geometry defaults and led_data bit positions for the LED chain receiver.
package led_pkg;

  localparam int LED_WIDTH_DEF        = 32;
  localparam int LED_CHAIN_LENGTH_DEF = 4;
  localparam int LED_NBANKS_DEF       = 16;
  localparam int LED_DATA_W_DEF       = 6;

  // Bit positions within led_data: upper half-panel RGB, then lower half-panel RGB.
  localparam int LED_R0 = 0;
  localparam int LED_G0 = 1;
  localparam int LED_B0 = 2;
  localparam int LED_R1 = 3;
  localparam int LED_G1 = 4;
  localparam int LED_B1 = 5;

  localparam int OE_CNT_W = 24;

endpackage

// File: rtl/led_chain_receiver_edge_sync.sv
// Three-stage synchronizer for one panel pin with a registered rising-edge pulse.
module led_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [2:0] sync_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr <= '0;
      rise    <= 1'b0;
    end else begin
      sync_sr <= {sync_sr[1:0], din};
      rise    <= sync_sr[1] & ~sync_sr[2];
    end
  end

endmodule

// File: rtl/led_chain_receiver.sv
// Snoops a HUB75-style LED panel bus and latches each shifted row for readback.
// Optional lit-time measurement is built when LED_RX_OE_MEASURE_EN is defined.
module led_chain_receiver
  import led_pkg::*;
#(
  parameter  int C_LED_WIDTH        = LED_WIDTH_DEF,
  parameter  int C_LED_CHAIN_LENGTH = LED_CHAIN_LENGTH_DEF,
  parameter  int C_LED_NBANKS       = LED_NBANKS_DEF,
  parameter  int C_DATA_W           = LED_DATA_W_DEF,
  localparam int N                  = C_LED_WIDTH * C_LED_CHAIN_LENGTH,
  localparam int XW                 = $clog2(N),
  localparam int BW                 = $clog2(C_LED_NBANKS)
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                led_clk,
  input  logic                led_stb,
  input  logic                led_oe,
  input  logic [BW-1:0]       led_bank,
  input  logic [C_DATA_W-1:0] led_data,
  output logic                row_valid,
  output logic [BW-1:0]       row_bank,
  output logic [XW:0]         row_pixels,
  output logic                row_len_err,
  output logic                frame_stb,
  input  logic [XW-1:0]       rd_addr,
  output logic [C_DATA_W-1:0] rd_data,
  output logic [23:0]         oe_cycles
);

  localparam logic [XW:0]   CNT_N    = (XW+1)'(N);
  localparam logic [XW:0]   CNT_MAX  = (XW+1)'(N + 1);
  localparam logic [BW-1:0] BANK_MAX = BW'(C_LED_NBANKS - 1);

  logic clk_rise;
  logic stb_rise;

  led_edge_sync u_clk_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .din   (led_clk),
    .rise  (clk_rise)
  );

  led_edge_sync u_stb_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .din   (led_stb),
    .rise  (stb_rise)
  );

  // Three stages so the level seen here lines up with the registered edge pulses.
  logic [C_DATA_W-1:0] data_s1, data_s2, data_s3;
  logic [BW-1:0]       bank_s1, bank_s2, bank_s3;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      data_s1 <= '0;
      data_s2 <= '0;
      data_s3 <= '0;
      bank_s1 <= '0;
      bank_s2 <= '0;
      bank_s3 <= '0;
    end else begin
      data_s1 <= led_data;
      data_s2 <= data_s1;
      data_s3 <= data_s2;
      bank_s1 <= led_bank;
      bank_s2 <= bank_s1;
      bank_s3 <= bank_s2;
    end
  end

  logic [C_DATA_W-1:0] shreg [N];
  logic [C_DATA_W-1:0] latch [N];

  // On a coincident clk/stb edge the latch copies the pre-shift contents.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < N; i++) begin
        shreg[i] <= '0;
        latch[i] <= '0;
      end
    end else begin
      if (clk_rise) begin
        shreg[0] <= data_s3;
        for (int i = 1; i < N; i++) shreg[i] <= shreg[i-1];
      end
      if (stb_rise) latch <= shreg;
    end
  end

  logic [XW:0]   pix_cnt;
  logic [BW-1:0] prev_bank;
  logic          prev_seen;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pix_cnt     <= '0;
      row_valid   <= 1'b0;
      row_bank    <= '0;
      row_pixels  <= '0;
      row_len_err <= 1'b0;
      frame_stb   <= 1'b0;
      prev_bank   <= '0;
      prev_seen   <= 1'b0;
    end else begin
      row_valid <= stb_rise;
      frame_stb <= 1'b0;
      if (stb_rise) begin
        row_bank    <= bank_s3;
        row_pixels  <= pix_cnt;
        row_len_err <= (pix_cnt != CNT_N);
        frame_stb   <= prev_seen && (prev_bank == BANK_MAX) && (bank_s3 == '0);
        prev_bank   <= bank_s3;
        prev_seen   <= 1'b1;
        pix_cnt     <= clk_rise ? (XW+1)'(1) : '0;
      end else if (clk_rise && (pix_cnt != CNT_MAX)) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  // Address 0 is the first pixel clocked in, which sits at the far end of the chain.
  logic [XW-1:0] rd_idx;
  logic          rd_in_range;

  assign rd_idx      = XW'(N - 1) - rd_addr;
  assign rd_in_range = ({1'b0, rd_addr} < CNT_N);
  assign rd_data     = rd_in_range ? latch[rd_idx] : '0;

`ifdef LED_RX_OE_MEASURE_EN
  logic [2:0]          oe_sr;
  logic [OE_CNT_W-1:0] oe_cnt;
  logic                oe_low;

  assign oe_low = ~oe_sr[2];

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      oe_sr     <= '1;
      oe_cnt    <= '0;
      oe_cycles <= '0;
    end else begin
      oe_sr <= {oe_sr[1:0], led_oe};
      if (stb_rise) begin
        oe_cycles <= oe_cnt;
        oe_cnt    <= oe_low ? OE_CNT_W'(1) : '0;
      end else if (oe_low && (oe_cnt != '1)) begin
        oe_cnt <= oe_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_oe;

  assign unused_oe = led_oe;
  assign oe_cycles = '0;
`endif

endmodule

// File: tb/tb_led_chain_receiver.sv
// Directed bench for led_chain_receiver: a small row/frame model feeds a scoreboard
// queue that a monitor drains whenever row_valid pulses.
module tb_led_chain_receiver;

  localparam int N  = 128;
  localparam int NB = 16;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       led_clk = 1'b0;
  logic       led_stb = 1'b0;
  logic       led_oe  = 1'b1;
  logic [3:0] led_bank = '0;
  logic [5:0] led_data = '0;
  logic [6:0] rd_addr  = '0;
  logic        row_valid;
  logic [3:0]  row_bank;
  logic [7:0]  row_pixels;
  logic        row_len_err;
  logic        frame_stb;
  logic [5:0]  rd_data;
  logic [23:0] oe_cycles;

  led_chain_receiver dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .led_clk     (led_clk),
    .led_stb     (led_stb),
    .led_oe      (led_oe),
    .led_bank    (led_bank),
    .led_data    (led_data),
    .row_valid   (row_valid),
    .row_bank    (row_bank),
    .row_pixels  (row_pixels),
    .row_len_err (row_len_err),
    .frame_stb   (frame_stb),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .oe_cycles   (oe_cycles)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [3:0] bank;
    logic [7:0] pixels;
    logic       err;
    logic       frame;
  } row_t;

  row_t exp_q[$];
  row_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_frames  = 0;
  int   seen_frames = 0;

  logic [5:0] m_sh  [N];
  logic [5:0] m_lat [N];
  int         m_cnt = 0;
  logic [3:0] m_prev = '0;
  bit         m_seen = 1'b0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge sys_clk) begin
    #1;
    if (frame_stb) seen_frames++;
    if (row_valid) begin
      if (exp_q.size() == 0) begin
        check("row_valid_unexpected", row_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("row_bank", row_bank, mon_e.bank);
        check("row_pixels", row_pixels, mon_e.pixels);
        check("row_len_err", row_len_err, mon_e.err);
        check("frame_stb", frame_stb, mon_e.frame);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sh[i]  = '0;
      m_lat[i] = '0;
    end
    m_cnt  = 0;
    m_prev = '0;
    m_seen = 1'b0;
  endtask

  task automatic model_shift(logic [5:0] d);
    for (int i = N - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
    m_sh[0] = d;
    if (m_cnt < N + 1) m_cnt++;
  endtask

  task automatic model_latch(logic [3:0] b);
    row_t e;
    e.bank   = b;
    e.pixels = 8'(m_cnt);
    e.err    = (m_cnt != N);
    e.frame  = m_seen && (m_prev == 4'(NB - 1)) && (b == 4'd0);
    if (e.frame) exp_frames++;
    exp_q.push_back(e);
    m_prev = b;
    m_seen = 1'b1;
    m_lat  = m_sh;
    m_cnt  = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge sys_clk);
    if (exp_q.size() != 0) begin
      check("row_valid_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic pin_shift(logic [5:0] d);
    led_data = d;
    repeat (2) @(negedge sys_clk);
    led_clk = 1'b1;
    repeat (2) @(negedge sys_clk);
    led_clk = 1'b0;
    model_shift(d);
  endtask

  task automatic pin_row(int count, int mult, int base);
    for (int x = 0; x < count; x++) pin_shift(6'((x * mult + base) % 64));
  endtask

  task automatic pin_strobe(logic [3:0] b);
    led_bank = b;
    repeat (2) @(negedge sys_clk);
    led_stb = 1'b1;
    model_latch(b);
    repeat (3) @(negedge sys_clk);
    led_stb = 1'b0;
    repeat (2) @(negedge sys_clk);
    wait_drain();
  endtask

  task automatic pin_coincide(logic [5:0] d, logic [3:0] b);
    led_bank = b;
    led_data = d;
    repeat (2) @(negedge sys_clk);
    led_clk = 1'b1;
    led_stb = 1'b1;
    model_latch(b);
    model_shift(d);
    repeat (3) @(negedge sys_clk);
    led_clk = 1'b0;
    led_stb = 1'b0;
    repeat (2) @(negedge sys_clk);
    wait_drain();
  endtask

  task automatic check_rd(string tag, int addr);
    rd_addr = 7'(addr);
    #1;
    check(tag, rd_data, m_lat[N - 1 - addr]);
  endtask

  task automatic check_reset_outputs();
    check("rst_row_valid", row_valid, 0);
    check("rst_row_bank", row_bank, 0);
    check("rst_row_pixels", row_pixels, 0);
    check("rst_row_len_err", row_len_err, 0);
    check("rst_frame_stb", frame_stb, 0);
    check("rst_oe_cycles", oe_cycles, 0);
    rd_addr = 7'd5;
    #1;
    check("rst_rd_data", rd_data, 0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (3) @(negedge sys_clk);
    check_reset_outputs();
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge sys_clk);
    check_reset_outputs();
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Full row, values x mod 64, bank 5.
    pin_row(N, 1, 0);
    pin_strobe(4'd5);
    rd_addr = 7'd10;
    #1;
    check("rd_addr10_literal", rd_data, 10);
    check_rd("rd_addr0", 0);
    check_rd("rd_addr127", 127);
    repeat (50) @(negedge sys_clk);
    check_rd("rd_idle_hold", 10);

    // Short and overlong rows.
    pin_row(127, 1, 3);
    pin_strobe(4'd3);
    check_rd("rd_short_row", 0);
    pin_row(200, 1, 7);
    pin_strobe(4'd3);
    check_rd("rd_long_row", 0);

    // Bank sweep; frame wrap only on the second bank-0 latch.
    for (int b = 0; b < NB; b++) pin_strobe(4'(b));
    pin_strobe(4'd0);
    check("frame_count_sweep", seen_frames, exp_frames);

    // Coincident clk/stb edge after a full row.
    pin_row(N, 3, 1);
    pin_coincide(6'd42, 4'd7);
    check_rd("coin_rd0", 0);
    check_rd("coin_rd64", 64);
    check_rd("coin_rd127", 127);
    pin_strobe(4'd7);
    check_rd("coin_next_rd127", 127);

    // Lit-time measurement between two strobes.
    pin_strobe(4'd1);
    led_oe = 1'b0;
    repeat (500) @(negedge sys_clk);
    led_oe = 1'b1;
    repeat (3) @(negedge sys_clk);
    pin_strobe(4'd2);
`ifdef LED_RX_OE_MEASURE_EN
    check("oe_cycles", oe_cycles, 500);
`else
    check("oe_cycles", oe_cycles, 0);
`endif

    // Reset mid-row discards the partial row and forgets the previous bank.
    pin_strobe(4'(NB - 1));
    pin_row(60, 1, 9);
    do_reset();
    pin_row(N, 1, 11);
    pin_strobe(4'd0);
    check_rd("post_rst_rd5", 5);
    check("frame_count_total", seen_frames, exp_frames);

    repeat (5) @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
